// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the multicycle RV32I core control path: FSM state
// type, ALUOp codes handed to ALU_CONTROL, base opcodes, branch funct3
// values, and the datapath mux select encodings.
// ---------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEMADR   = 4'd3,
      ST_MEMREAD  = 4'd4,
      ST_MEMWB    = 4'd5,
      ST_MEMWRITE = 4'd6,
      ST_EXEC_R   = 4'd7,
      ST_EXEC_I   = 4'd8,
      ST_UPPER    = 4'd9,
      ST_ALUWB    = 4'd10,
      ST_BRANCH   = 4'd11,
      ST_JAL      = 4'd12,
      ST_TRAP     = 4'd13
   } state_t;

   // ALUOp encodings consumed by ALU_CONTROL
   localparam logic [2:0] ALUOP_R  = 3'b000;
   localparam logic [2:0] ALUOP_B  = 3'b001;
   localparam logic [2:0] ALUOP_LS = 3'b010;
   localparam logic [2:0] ALUOP_I  = 3'b011;
   localparam logic [2:0] ALUOP_U  = 3'b100;

   // RV32I base opcodes
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Branch conditions supported by the condition function
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_main_control.sv
// ---------------------------------------------------------------------------
// multicycle_main_control
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback, and drives ALUOp for ALU_CONTROL.
//
// Ports
//   CLK, RST_n            clock, asynchronous active-low reset
//   opcode, funct3        instruction fields from the instruction register
//   zero                  ALU zero flag (current cycle)
//   mem_ready             memory accepted/completed the current access
//   mem_req, mem_we       memory request and its write qualifier
//   adr_src               memory address select (PC / ALUOut)
//   ir_write, pc_write    IR+oldPC load, PC load
//   reg_write             register file write enable
//   alu_src_a, alu_src_b  ALU operand selects
//   result_src            result mux select
//   ALUOp                 ALU operation class
//   illegal               sticky illegal-opcode flag (TRAP state)
// ---------------------------------------------------------------------------
module multicycle_main_control
   import cpu_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [2:0] ALUOp,
   output logic       illegal
);

   state_t state_q;
   state_t state_d;

   // Only BEQ and BNE redirect the PC; every other funct3 falls through.
   function automatic logic branch_taken(input logic [2:0] f3, input logic z);
      return ((f3 == F3_BEQ) && z) || ((f3 == F3_BNE) && !z);
   endfunction

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     state_d = ST_FETCH;
         ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OPC_LOAD, OPC_STORE: state_d = ST_MEMADR;
               OPC_OP:              state_d = ST_EXEC_R;
               OPC_OPIMM:           state_d = ST_EXEC_I;
               OPC_BRANCH:          state_d = ST_BRANCH;
               OPC_JAL:             state_d = ST_JAL;
               OPC_LUI, OPC_AUIPC:  state_d = ST_UPPER;
               default:             state_d = ST_TRAP;
            endcase
         end
         // Only loads and stores reach MEMADR, so anything not a load is a store.
         ST_MEMADR:   state_d = (opcode == OPC_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
         ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
         ST_MEMWB:    state_d = ST_FETCH;
         ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
         ST_EXEC_R:   state_d = ST_ALUWB;
         ST_EXEC_I:   state_d = ST_ALUWB;
         ST_UPPER:    state_d = ST_ALUWB;
         ST_ALUWB:    state_d = ST_FETCH;
         ST_BRANCH:   state_d = ST_FETCH;
         // JAL writes the target into PC now and oldPC+4 into rd next cycle.
         ST_JAL:      state_d = ST_ALUWB;
         ST_TRAP:     state_d = ST_TRAP;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output decode: Moore outputs, plus mem_ready gating in FETCH and the
   // branch condition in BRANCH.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      ALUOp      = ALUOP_R;
      illegal    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_req    = 1'b1;
            adr_src    = 1'b0;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            ALUOp      = ALUOP_LS;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         ST_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            ALUOp     = ALUOP_LS;
         end
         ST_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            ALUOp     = ALUOP_LS;
         end
         ST_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         ST_MEMWB: begin
            result_src = RES_MEM;
            reg_write  = 1'b1;
         end
         ST_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         ST_EXEC_R: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            ALUOp     = ALUOP_R;
         end
         ST_EXEC_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            ALUOp     = ALUOP_I;
         end
         ST_UPPER: begin
            // LUI adds the immediate to zero, AUIPC to the instruction's PC.
            alu_src_a = (opcode == OPC_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            ALUOp     = ALUOP_U;
         end
         ST_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            ALUOp      = ALUOP_B;
            result_src = RES_ALUOUT;
            pc_write   = branch_taken(funct3, zero);
         end
         ST_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            ALUOp      = ALUOP_LS;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
         end
         ST_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_main_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_control
// Directed bench for the main control FSM. The stimulus process pushes the
// hand-computed output vector expected for each cycle into a queue; a monitor
// samples the DUT on the falling edge and compares against the queue head.
// Vector layout: {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
//                 alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], ALUOp[2:0],
//                 illegal}
// ---------------------------------------------------------------------------
module tb_multicycle_main_control;

   logic       CLK;
   logic       RST_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [2:0] ALUOp;
   logic       illegal;

   multicycle_main_control dut (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .opcode     (opcode),
      .funct3     (funct3),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .ALUOp      (ALUOp),
      .illegal    (illegal)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] v;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   logic [15:0] act;
   assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, ALUOp, illegal};

   function automatic logic [15:0] mk(input logic mreq, input logic mwe, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] res, input logic [2:0] op,
                                      input logic ill);
      return {mreq, mwe, adr, irw, pcw, rw, a, b, res, op, ill};
   endfunction

   // Expected vectors, written out by hand from the state descriptions.
   logic [15:0] E_ZERO, E_FWAIT, E_FRDY, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR;
   logic [15:0] E_EXR, E_EXI, E_LUI, E_AUI, E_AWB, E_BRT, E_BRN, E_JAL, E_TRAP;

   // Monitor: compare the DUT against the queue head on every falling edge.
   always @(negedge CLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got=%b want=%b (t=%0t)", e.nm, act, e.v, $time);
         end
      end
   end

   // One clock cycle: apply inputs, queue the expected output for this cycle.
   task automatic cyc(input logic rdy, input logic z, input logic [15:0] e, input string nm);
      exp_t x;
      x.v = e;
      x.nm = nm;
      q.push_back(x);
      mem_ready = rdy;
      zero = z;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      E_ZERO  = '0;
      E_FWAIT = mk(1,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 3'b010, 0);
      E_FRDY  = mk(1,0,0,1,1,0, 2'b00, 2'b10, 2'b10, 3'b010, 0);
      E_DEC   = mk(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 3'b010, 0);
      E_MADR  = mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 3'b010, 0);
      E_MRD   = mk(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      E_MWB   = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b01, 3'b000, 0);
      E_MWR   = mk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      E_EXR   = mk(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 3'b000, 0);
      E_EXI   = mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 3'b011, 0);
      E_LUI   = mk(0,0,0,0,0,0, 2'b11, 2'b01, 2'b00, 3'b100, 0);
      E_AUI   = mk(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 3'b100, 0);
      E_AWB   = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      E_BRT   = mk(0,0,0,0,1,0, 2'b10, 2'b00, 2'b00, 3'b001, 0);
      E_BRN   = mk(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 3'b001, 0);
      E_JAL   = mk(0,0,0,0,1,0, 2'b01, 2'b10, 2'b00, 3'b010, 0);
      E_TRAP  = mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1);

      RST_n = 1'b0;
      opcode = 7'b0110011;
      funct3 = 3'b000;
      zero = 1'b0;
      mem_ready = 1'b0;
      @(posedge CLK);
      #1;

      // Reset held, then one IDLE cycle after release
      cyc(1, 0, E_ZERO, "reset_hold0");
      cyc(1, 1, E_ZERO, "reset_hold1");
      RST_n = 1'b1;
      cyc(1, 0, E_ZERO, "idle");

      // add with three wait cycles on fetch; mem_ready in DECODE is ignored
      for (int i = 0; i < 3; i++) cyc(0, 0, E_FWAIT, "add_fetch_wait");
      cyc(1, 0, E_FRDY, "add_fetch_rdy");
      cyc(1, 0, E_DEC,  "add_decode");
      cyc(0, 0, E_EXR,  "add_exec_r");
      cyc(0, 0, E_AWB,  "add_aluwb");

      // lw, zero-wait: 5 cycles
      opcode = 7'b0000011;
      cyc(1, 0, E_FRDY, "lw_fetch");
      cyc(0, 0, E_DEC,  "lw_decode");
      cyc(0, 0, E_MADR, "lw_memadr");
      cyc(1, 0, E_MRD,  "lw_memread");
      cyc(0, 0, E_MWB,  "lw_memwb");

      // sw with one wait cycle in MEMWRITE, then zero-wait sw: 4 cycles
      opcode = 7'b0100011;
      cyc(1, 0, E_FRDY, "sw_fetch");
      cyc(0, 0, E_DEC,  "sw_decode");
      cyc(0, 0, E_MADR, "sw_memadr");
      cyc(0, 0, E_MWR,  "sw_memwrite_wait");
      cyc(1, 0, E_MWR,  "sw_memwrite");
      cyc(1, 0, E_FRDY, "sw2_fetch");
      cyc(0, 0, E_DEC,  "sw2_decode");
      cyc(0, 0, E_MADR, "sw2_memadr");
      cyc(1, 0, E_MWR,  "sw2_memwrite");

      // addi
      opcode = 7'b0010011;
      cyc(1, 0, E_FRDY, "addi_fetch");
      cyc(0, 0, E_DEC,  "addi_decode");
      cyc(0, 0, E_EXI,  "addi_exec_i");
      cyc(0, 0, E_AWB,  "addi_aluwb");

      // lui / auipc
      opcode = 7'b0110111;
      cyc(1, 0, E_FRDY, "lui_fetch");
      cyc(0, 0, E_DEC,  "lui_decode");
      cyc(0, 0, E_LUI,  "lui_upper");
      cyc(0, 0, E_AWB,  "lui_aluwb");
      opcode = 7'b0010111;
      cyc(1, 0, E_FRDY, "auipc_fetch");
      cyc(0, 0, E_DEC,  "auipc_decode");
      cyc(0, 0, E_AUI,  "auipc_upper");
      cyc(0, 0, E_AWB,  "auipc_aluwb");

      // Branches: 3 cycles each, pc_write from funct3/zero
      opcode = 7'b1100011;
      funct3 = 3'b000;
      cyc(1, 0, E_FRDY, "beq_fetch");
      cyc(0, 0, E_DEC,  "beq_decode");
      cyc(0, 1, E_BRT,  "beq_z1_taken");
      cyc(1, 0, E_FRDY, "beq2_fetch");
      cyc(0, 0, E_DEC,  "beq2_decode");
      cyc(0, 0, E_BRN,  "beq_z0_not_taken");
      funct3 = 3'b001;
      cyc(1, 0, E_FRDY, "bne_fetch");
      cyc(0, 0, E_DEC,  "bne_decode");
      cyc(0, 1, E_BRN,  "bne_z1_not_taken");
      cyc(1, 0, E_FRDY, "bne2_fetch");
      cyc(0, 0, E_DEC,  "bne2_decode");
      cyc(0, 0, E_BRT,  "bne_z0_taken");
      funct3 = 3'b100;
      cyc(1, 0, E_FRDY, "blt_fetch");
      cyc(0, 0, E_DEC,  "blt_decode");
      cyc(0, 1, E_BRN,  "f3_100_z1_no_write");
      cyc(1, 0, E_FRDY, "blt2_fetch");
      cyc(0, 0, E_DEC,  "blt2_decode");
      cyc(0, 0, E_BRN,  "f3_100_z0_no_write");

      // jal: 4 cycles
      opcode = 7'b1101111;
      cyc(1, 0, E_FRDY, "jal_fetch");
      cyc(0, 0, E_DEC,  "jal_decode");
      cyc(0, 0, E_JAL,  "jal_jal");
      cyc(0, 0, E_AWB,  "jal_aluwb");

      // Illegal opcode: TRAP absorbs, ignores mem_ready, until reset
      opcode = 7'b0000000;
      cyc(1, 0, E_FRDY, "ill_fetch");
      cyc(0, 0, E_DEC,  "ill_decode");
      for (int i = 0; i < 20; i++) cyc(i[0], 0, E_TRAP, "trap_hold");
      RST_n = 1'b0;
      cyc(0, 0, E_ZERO, "trap_reset");
      RST_n = 1'b1;
      cyc(0, 0, E_ZERO, "trap_idle");
      opcode = 7'b0000011;
      cyc(1, 0, E_FRDY, "post_trap_fetch");

      // Async reset while waiting in MEMREAD
      cyc(0, 0, E_DEC,  "rst_lw_decode");
      cyc(0, 0, E_MADR, "rst_lw_memadr");
      cyc(0, 0, E_MRD,  "rst_lw_memread_wait");
      begin
         exp_t x;
         x.v = E_ZERO;
         x.nm = "async_reset_memread";
         q.push_back(x);
         mem_ready = 1'b0;
         #1 RST_n = 1'b0;
         @(posedge CLK);
         #1;
      end
      RST_n = 1'b1;
      cyc(0, 0, E_ZERO,  "rst_idle");
      cyc(0, 0, E_FWAIT, "rst_fetch");

      @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL queue_drain: got=%0d want=0", q.size());
      end
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
